// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width and the master FSM state encoding,
// also used by spi_slave benches.
package spi_pkg;

  localparam int SPI_FRAME_W = 48;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    FINISH   = 2'd3
  } spi_state_e;

  function automatic logic is_shift_state(input spi_state_e s);
    return (s == SHIFT_LO) || (s == SHIFT_HI);
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Half-period timer: pulses tick_o on the last cycle of each HALF_DIV-long
// phase while run_i is high, and holds at zero otherwise.
module spi_phase_timer #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic tick_o
);

  localparam int              PH_W    = $clog2(HALF_DIV + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_DIV - 1);

  logic [PH_W-1:0] cnt_q, cnt_d;

  // Phase counter next state; restarts from zero at every phase boundary.
  always_comb begin
    tick_o = 1'b0;
    cnt_d  = '0;
    if (run_i) begin
      if (cnt_q == PH_LAST) begin
        tick_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + PH_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_frame_master.sv
// SPI frame master: shifts one FRAME_W-bit frame MSB first to an spi_slave,
// mode-0 style (data changes with clock low, slave samples on rising edge).
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int FRAME_W  = SPI_FRAME_W,
  parameter int HALF_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               abort,
  output logic               master_clk,
  output logic               master_chip_select,
  output logic               master_data,
  output logic               busy,
  output logic               done
);

  localparam int               CNT_W    = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               mclk_q, mclk_d;
  logic               cs_q, cs_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               phase_tick;

  spi_phase_timer #(
    .HALF_DIV (HALF_DIV)
  ) u_phase_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (is_shift_state(state_q)),
    .tick_o (phase_tick)
  );

  // Next-state logic; outputs are decoded from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          shift_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = SHIFT_LO;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT_LO: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_tick) begin
          state_d = SHIFT_HI;
        end else begin
          state_d = SHIFT_LO;
        end
      end
      SHIFT_HI: begin
        if (abort) begin
          state_d = IDLE;
        end else if (phase_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = FINISH;
          end else begin
            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            state_d   = SHIFT_LO;
          end
        end else begin
          state_d = SHIFT_HI;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d    = is_shift_state(state_d);
    mclk_d  = (state_d == SHIFT_HI);
    data_d  = cs_d ? shift_d[FRAME_W-1] : 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    ready_d = (state_d == IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      mclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      data_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      mclk_q    <= mclk_d;
      cs_q      <= cs_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_ready           = ready_q;
  assign master_clk         = mclk_q;
  assign master_chip_select = cs_q;
  assign master_data        = data_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule
